// File: rtl/frame_splitter_if.sv
// frame_splitter_if: sample-in / frame-out stream bundle
// in_valid,x_in in (no backpressure); out_* valid/ready stream out
interface frame_splitter_if #(
  parameter int SAMPLE_WIDTH = 16
) ();
  logic                    in_valid;
  logic [SAMPLE_WIDTH-1:0] x_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [SAMPLE_WIDTH-1:0] out_sample;
  logic                    out_first;
  logic                    out_last;

  modport slave (
    input  in_valid,
    input  x_in,
    input  out_ready,
    output out_valid,
    output out_sample,
    output out_first,
    output out_last
  );

  modport master (
    output in_valid,
    output x_in,
    output out_ready,
    input  out_valid,
    input  out_sample,
    input  out_first,
    input  out_last
  );
endinterface

// File: rtl/frame_splitter.sv
// frame_splitter: circular buffer re-emitting samples as overlapping frames
// ports: clk, rst (async high), bus (slave), frame_cnt, overflow (sticky)
module frame_splitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 400,
  parameter int HOP_LEN      = 160,
  parameter int BUF_DEPTH    = 512
) (
  input  logic        clk,
  input  logic        rst,
  frame_splitter_if.slave bus,
  output logic [15:0] frame_cnt,
  output logic        overflow
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int AW = PW + 1;
  localparam int IW = (FRAME_LEN > 1) ?
                      $clog2(FRAME_LEN) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] A_FULL   = AW'(BUF_DEPTH);
  localparam logic [AW-1:0] A_FRAME  = AW'(FRAME_LEN);
  localparam logic [AW-1:0] A_HOP    = AW'(HOP_LEN);
  localparam logic [PW-1:0] P_HOP    = PW'(HOP_LEN);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];
  logic [SAMPLE_WIDTH-1:0] rd_q;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] frame_base;
  logic [AW-1:0] avail;
  logic [IW-1:0] idx;
  logic [1:0]    state;

  logic valid;
  logic wr_en;
  logic hs;
  logic hs_last;
  logic rd_en;

  assign valid = (state == STREAM);

  // rd_ptr always points at the next sample to fetch, so a
  // handshake fetches its successor in the same cycle.
  always_comb begin
    wr_en   = bus.in_valid && (avail != A_FULL);
    hs      = valid && bus.out_ready;
    hs_last = hs && (idx == IDX_LAST);
    rd_en   = (state == LOAD) || (hs && !hs_last);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.x_in;
  end

  // The read register only loads on a fetch, so it holds the
  // presented sample through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_q <= '0;
    else if (rd_en) rd_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (bus.in_valid && !wr_en)
        overflow <= 1'b1;
    end
  end

  // Net update covers a write and a frame retire together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      avail <= '0;
    else
      avail <= avail + AW'(wr_en)
             - (hs_last ? A_HOP : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      frame_base <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (avail >= A_FRAME) begin
            state  <= LOAD;
            rd_ptr <= frame_base;
            idx    <= '0;
          end
        end
        LOAD: begin
          state  <= STREAM;
          rd_ptr <= rd_ptr + PW'(1);
        end
        STREAM: begin
          if (hs_last) begin
            state      <= IDLE;
            frame_base <= frame_base + P_HOP;
            frame_cnt  <= frame_cnt + 16'd1;
          end else if (hs) begin
            idx    <= idx + IW'(1);
            rd_ptr <= rd_ptr + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = valid;
  assign bus.out_sample = rd_q;
  assign bus.out_first  = valid && (idx == '0);
  assign bus.out_last   = valid && (idx == IDX_LAST);

endmodule

// File: tb/tb_frame_splitter.sv
// tb_frame_splitter: directed vectors for frame_splitter
// FRAME_LEN=8, HOP_LEN=4, BUF_DEPTH=16
module tb_frame_splitter;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_cnt;
  logic        overflow;

  frame_splitter_if #(.SAMPLE_WIDTH(W)) bus ();

  frame_splitter #(
    .SAMPLE_WIDTH(W),
    .FRAME_LEN(8),
    .HOP_LEN(4),
    .BUF_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .frame_cnt(frame_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q_s [$];
  logic [1:0]   q_fl [$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_s;
  logic [1:0]   prev_fl;

  typedef struct {
    int base;
    int nsamp;
    int gap;
    bit hold;
    int frames;
    bit ovf;
  } vec_t;

  vec_t vt [5];
  bit   pat [4];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(bus.out_valid), 1);
        chk("stall_sample", int'(bus.out_sample),
            int'(prev_s));
        chk("stall_flags",
            int'({bus.out_first, bus.out_last}),
            int'(prev_fl));
      end
      if (bus.out_valid && bus.out_ready) begin
        q_s.push_back(bus.out_sample);
        q_fl.push_back({bus.out_first, bus.out_last});
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_s     = bus.out_sample;
      prev_fl    = {bus.out_first, bus.out_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_flags",
        int'({bus.out_first, bus.out_last}), 0);
    chk("rst_sample", int'(bus.out_sample), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    q_s.delete();
    q_fl.delete();
  endtask

  task automatic feed_one(int v, int gap);
    bus.in_valid = 1'b1;
    bus.x_in     = W'(v);
    tick();
    bus.in_valid = 1'b0;
    for (int g = 1; g < gap; g++) tick();
  endtask

  task automatic wait_samples(int n, int limit,
                              string name);
    int c;
    c = 0;
    while (q_s.size() < n && c < limit) begin
      tick();
      c++;
    end
    if (q_s.size() < n)
      chk(name, q_s.size(), n);
  endtask

  task automatic check_frames(int base, int nf,
                              string tag);
    logic [W-1:0] e;
    int n;
    int k;
    int i;
    chk({tag, "_count"}, q_s.size(), nf * 8);
    n = (q_s.size() < nf * 8) ? q_s.size() : nf * 8;
    for (int j = 0; j < n; j++) begin
      k = j / 8;
      i = j % 8;
      e = W'(base + 4 * k + i);
      chk($sformatf("%s_f%0d_s%0d", tag, k, i),
          int'(q_s[j]), int'(e));
      chk($sformatf("%s_f%0d_fl%0d", tag, k, i),
          int'(q_fl[j]), int'({i == 0, i == 7}));
    end
  endtask

  initial begin
    vt[0] = '{0,   8,  3, 1'b0, 1, 1'b0};
    vt[1] = '{0,   20, 3, 1'b0, 4, 1'b0};
    vt[2] = '{0,   20, 1, 1'b1, 3, 1'b1};
    vt[3] = '{0,   40, 3, 1'b0, 9, 1'b0};
    vt[4] = '{-50, 12, 2, 1'b0, 2, 1'b0};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b0;

    for (int t = 0; t < 5; t++) begin
      reset_dut();
      bus.out_ready = !vt[t].hold;
      for (int i = 0; i < vt[t].nsamp; i++) begin
        feed_one(vt[t].base + i, vt[t].gap);
        if (vt[t].hold && i == 15)
          chk("ovf_before_17th", int'(overflow), 0);
        if (vt[t].hold && i == 16)
          chk("ovf_after_17th", int'(overflow), 1);
      end
      bus.out_ready = 1'b1;
      wait_samples(vt[t].frames * 8, 500,
                   $sformatf("v%0d_timeout", t));
      repeat (30) tick();
      check_frames(vt[t].base, vt[t].frames,
                   $sformatf("v%0d", t));
      chk($sformatf("v%0d_frame_cnt", t),
          int'(frame_cnt), vt[t].frames);
      chk($sformatf("v%0d_overflow", t),
          int'(overflow), int'(vt[t].ovf));
    end

    // ready toggling 1-0-0-1 while a frame streams
    reset_dut();
    for (int i = 0; i < 8; i++) feed_one(i, 1);
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = pat[c % 4];
      tick();
    end
    bus.out_ready = 1'b1;
    wait_samples(8, 100, "t3_timeout");
    repeat (20) tick();
    check_frames(0, 1, "t3");
    chk("t3_frame_cnt", int'(frame_cnt), 1);

    // reset in the middle of frame 1
    reset_dut();
    for (int i = 0; i < 12; i++) feed_one(i, 1);
    bus.out_ready = 1'b1;
    wait_samples(11, 200, "t6_timeout");
    chk("t6_pre_valid", int'(bus.out_valid), 1);
    chk("t6_pre_sample", int'(bus.out_sample), 7);
    chk("t6_pre_cnt", int'(frame_cnt), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(bus.out_valid), 0);
    chk("t6_rst_sample", int'(bus.out_sample), 0);
    chk("t6_rst_flags",
        int'({bus.out_first, bus.out_last}), 0);
    chk("t6_rst_cnt", int'(frame_cnt), 0);
    tick();
    rst = 1'b0;
    q_s.delete();
    q_fl.delete();
    for (int i = 0; i < 7; i++) feed_one(100 + i, 1);
    repeat (10) tick();
    chk("t6_no_early_out", q_s.size(), 0);
    chk("t6_no_early_valid", int'(bus.out_valid), 0);
    feed_one(107, 1);
    chk("t6_lat0_valid", int'(bus.out_valid), 0);
    tick();
    chk("t6_lat1_valid", int'(bus.out_valid), 0);
    tick();
    chk("t6_lat2_valid", int'(bus.out_valid), 1);
    chk("t6_lat2_first", int'(bus.out_first), 1);
    chk("t6_lat2_sample", int'(bus.out_sample), 100);
    wait_samples(8, 100, "t6b_timeout");
    repeat (20) tick();
    check_frames(100, 1, "t6b");
    chk("t6b_frame_cnt", int'(frame_cnt), 1);
    chk("t6b_overflow", int'(overflow), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
